// File: rtl/cci_mpf_prim_lockstep_qos_pkg.sv
// Shared types and QoS defaults for the lockstep QoS FIFO and its throttle FSMs.
package cci_mpf_prim_lockstep_qos_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        THROTTLE = 2'd1,
        HOLDOFF  = 2'd2
    } t_qos_state;

    typedef logic [5:0] t_qos_cycles;

    localparam logic        QOS_DEF_ENABLE       = 1'b1;
    localparam logic [7:0]  QOS_DEF_BEAT_DELTA   = 8'd6;
    localparam logic [7:0]  QOS_DEF_MIN_BEATS    = 8'd0;
    localparam t_qos_cycles QOS_DEF_THROTTLE_CYC = 6'd8;

endpackage

// File: rtl/cci_mpf_prim_qos_throttle.sv
// Per-channel throttle FSM: IDLE -> THROTTLE (Q cycles) -> HOLDOFF (Q cycles) -> IDLE.
module cci_mpf_prim_qos_throttle
    import cci_mpf_prim_lockstep_qos_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        trigger,
    input  logic        others_busy,
    input  t_qos_cycles quantum,
    output logic        throttled,
    output logic        busy
);

    t_qos_state  state_q, state_d;
    t_qos_cycles cnt_q, cnt_d;
    t_qos_cycles quantum_q, quantum_d;

    // State register; the quantum is latched at THROTTLE entry so later config writes do not disturb it
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            quantum_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quantum_q <= quantum_d;
        end
    end

    // Next-state logic; each non-idle phase counts down from the latched quantum
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quantum_d = quantum_q;
        case (state_q)
            IDLE: begin
                if (trigger && !others_busy) begin
                    state_d   = THROTTLE;
                    cnt_d     = quantum;
                    quantum_d = quantum;
                end
            end
            THROTTLE: begin
                if (cnt_q == t_qos_cycles'(1)) begin
                    state_d = HOLDOFF;
                    cnt_d   = quantum_q;
                end else begin
                    cnt_d = cnt_q - t_qos_cycles'(1);
                end
            end
            HOLDOFF: begin
                if (cnt_q == t_qos_cycles'(1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - t_qos_cycles'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the registered state only
    always_comb begin
        throttled = (state_q == THROTTLE);
        busy      = (state_q != IDLE);
    end

endmodule

// File: rtl/cci_mpf_prim_lockstep_qos_fifo.sv
// N-channel lockstep request FIFO with per-channel beat accounting and QoS throttling.
module cci_mpf_prim_lockstep_qos_fifo
    import cci_mpf_prim_lockstep_qos_pkg::*;
#(
    parameter int N_CHANNELS      = 2,
    parameter int N_DATA_BITS     = 64,
    parameter int THRESHOLD       = 8,
    parameter int N_ENTRIES       = 16,
    parameter int MAX_BEATS       = 4,
    parameter int REGISTER_OUTPUT = 0,
    localparam int BW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1
)
(
    input  logic                              clk,
    input  logic                              reset,
    input  logic [N_CHANNELS*N_DATA_BITS-1:0] enq_data,
    input  logic [N_CHANNELS-1:0]             enq_valid,
    input  logic [N_CHANNELS*BW-1:0]          enq_beats_m1,
    input  logic [N_CHANNELS-1:0]             enq_counted,
    output logic [N_CHANNELS-1:0]             almostFull,
    output logic [N_CHANNELS*N_DATA_BITS-1:0] first,
    output logic [N_CHANNELS-1:0]             first_valid,
    output logic                              notEmpty,
    input  logic                              deq_en,
    input  logic                              setqos,
    input  logic                              setqos_enable,
    input  logic [7:0]                        setqos_beat_delta,
    input  logic [7:0]                        setqos_min_beats,
    input  logic [5:0]                        setqos_throttle_cyc,
    output logic [N_CHANNELS-1:0]             throttled
);

    localparam int CH_W = N_DATA_BITS + 1 + BW + 1;
    localparam int EW   = N_CHANNELS * CH_W;
    localparam int PW   = $clog2(N_ENTRIES);
    localparam int CW   = $clog2(N_ENTRIES * MAX_BEATS) + 1;
    localparam int TW   = ((CW > 8) ? CW : 8) + 1;
    localparam logic [PW+1:0] AF_LEVEL = (PW+2)'(N_ENTRIES - THRESHOLD);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(N_ENTRIES - 1)) ? '0 : p + PW'(1);
    endfunction

    function automatic logic signed [CW+1:0] beat_count(input logic [BW-1:0] bm1);
        return $signed({{(CW+2-BW){1'b0}}, bm1}) + $signed((CW+2)'(1));
    endfunction

    logic                  enq_any, full, st_pop, head_present, out_occ, deq_fire, fifo_af;
    logic [EW-1:0]         enq_entry, head;
    logic [EW-1:0]         mem [N_ENTRIES];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [PW:0]           cnt_q;
    logic [PW+1:0]         occ;
    logic [N_CHANNELS-1:0] hd_vld, hd_cnt;
    logic [BW-1:0]         hd_bm1 [N_CHANNELS];

    assign enq_any  = |enq_valid;
    assign full     = (cnt_q == (PW+1)'(N_ENTRIES));
    assign deq_fire = deq_en && head_present;
    assign notEmpty = head_present;
    assign occ      = {1'b0, cnt_q} + {{(PW+1){1'b0}}, out_occ};
    assign fifo_af  = (occ >= AF_LEVEL);

    // Pack each channel as {data, valid, beats_m1, counted}
    always_comb begin
        enq_entry = '0;
        for (int c = 0; c < N_CHANNELS; c++) begin
            enq_entry[c*CH_W +: CH_W] = {enq_data[c*N_DATA_BITS +: N_DATA_BITS], enq_valid[c],
                                         enq_beats_m1[c*BW +: BW], enq_counted[c]};
        end
    end

    // Storage array write port (payload, never reset)
    always_ff @(posedge clk) begin
        if (enq_any) mem[wr_ptr_q] <= enq_entry;
    end

    // Storage pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (enq_any) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (st_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({enq_any, st_pop})
                2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    if (REGISTER_OUTPUT != 0) begin : g_reg_out
        logic [EW-1:0] out_q;
        logic          out_vld_q;

        assign st_pop       = (cnt_q != '0) && (!out_vld_q || deq_en);
        assign head         = out_q;
        assign head_present = out_vld_q;
        assign out_occ      = out_vld_q;

        // Output-register occupancy: refill whenever empty or being drained
        always_ff @(posedge clk) begin
            if (reset)       out_vld_q <= 1'b0;
            else if (st_pop) out_vld_q <= 1'b1;
            else if (deq_en) out_vld_q <= 1'b0;
        end

        // Output-register payload
        always_ff @(posedge clk) begin
            if (st_pop) out_q <= mem[rd_ptr_q];
        end
    end else begin : g_comb_out
        assign st_pop       = deq_en && (cnt_q != '0);
        assign head         = mem[rd_ptr_q];
        assign head_present = (cnt_q != '0);
        assign out_occ      = 1'b0;
    end

    // Unpack the head bundle; valids are masked while empty
    always_comb begin
        first       = '0;
        first_valid = '0;
        hd_vld      = '0;
        hd_cnt      = '0;
        for (int c = 0; c < N_CHANNELS; c++) begin
            first[c*N_DATA_BITS +: N_DATA_BITS] = head[c*CH_W + BW + 2 +: N_DATA_BITS];
            hd_vld[c]      = head[c*CH_W + BW + 1];
            hd_bm1[c]      = head[c*CH_W + 1 +: BW];
            hd_cnt[c]      = head[c*CH_W];
            first_valid[c] = head_present && hd_vld[c];
        end
    end

    logic [N_CHANNELS-1:0] enq_ev_q, deq_ev_q, beats_ok;
    logic [BW-1:0]         enq_bm1_q [N_CHANNELS];
    logic [BW-1:0]         deq_bm1_q [N_CHANNELS];
    logic [CW-1:0]         beats_q   [N_CHANNELS];
    logic [CW-1:0]         beats_d   [N_CHANNELS];

    // Beat events register one cycle, then the counter applies them the following cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            enq_ev_q <= '0;
            deq_ev_q <= '0;
            for (int c = 0; c < N_CHANNELS; c++) beats_q[c] <= '0;
        end else begin
            enq_ev_q <= enq_valid & enq_counted;
            deq_ev_q <= {N_CHANNELS{deq_fire}} & hd_vld & hd_cnt;
            for (int c = 0; c < N_CHANNELS; c++) beats_q[c] <= beats_d[c];
        end
    end

    // Beat sizes travelling with the events (payload, never reset)
    always_ff @(posedge clk) begin
        for (int c = 0; c < N_CHANNELS; c++) begin
            enq_bm1_q[c] <= enq_beats_m1[c*BW +: BW];
            deq_bm1_q[c] <= hd_bm1[c];
        end
    end

    // Next beat count per channel, computed wide so range violations are visible
    always_comb begin
        logic signed [CW+1:0] sum;
        sum      = '0;
        beats_ok = '0;
        for (int c = 0; c < N_CHANNELS; c++) begin
            sum = $signed({2'b00, beats_q[c]});
            if (enq_ev_q[c]) sum = sum + beat_count(enq_bm1_q[c]);
            if (deq_ev_q[c]) sum = sum - beat_count(deq_bm1_q[c]);
            beats_ok[c] = (sum[CW+1:CW] == 2'b00);
            beats_d[c]  = sum[CW-1:0];
        end
    end

    logic        qos_en_q;
    logic [7:0]  qos_delta_q, qos_min_q;
    t_qos_cycles qos_cyc_q;

    // QoS configuration; reset takes priority over a same-cycle setqos
    always_ff @(posedge clk) begin
        if (reset) begin
            qos_en_q    <= QOS_DEF_ENABLE;
            qos_delta_q <= QOS_DEF_BEAT_DELTA;
            qos_min_q   <= QOS_DEF_MIN_BEATS;
            qos_cyc_q   <= QOS_DEF_THROTTLE_CYC;
        end else if (setqos) begin
            qos_en_q    <= setqos_enable;
            qos_delta_q <= setqos_beat_delta;
            qos_min_q   <= setqos_min_beats;
            qos_cyc_q   <= setqos_throttle_cyc;
        end
    end

    logic [N_CHANNELS-1:0] trig, others_busy, busy;

    // Trigger: channel leads the slowest other channel by more than delta, and that channel is above the floor
    always_comb begin
        logic [TW-1:0] mo;
        mo   = '0;
        trig = '0;
        for (int c = 0; c < N_CHANNELS; c++) begin
            mo = '1;
            for (int j = 0; j < N_CHANNELS; j++) begin
                if (j != c && TW'(beats_q[j]) < mo) mo = TW'(beats_q[j]);
            end
            trig[c] = qos_en_q && (qos_cyc_q != '0) &&
                      (TW'(beats_q[c]) > mo + TW'(qos_delta_q)) && (mo > TW'(qos_min_q));
        end
    end

    // Arbitration: any active FSM blocks all others; simultaneous triggers go to the lowest index
    always_comb begin
        others_busy = '0;
        for (int c = 0; c < N_CHANNELS; c++) begin
            for (int j = 0; j < N_CHANNELS; j++) begin
                if (j != c && busy[j]) others_busy[c] = 1'b1;
                if (j < c && trig[j])  others_busy[c] = 1'b1;
            end
        end
    end

    for (genvar c = 0; c < N_CHANNELS; c++) begin : g_qos
        cci_mpf_prim_qos_throttle u_thr (
            .clk         (clk),
            .reset       (reset),
            .trigger     (trig[c]),
            .others_busy (others_busy[c]),
            .quantum     (qos_cyc_q),
            .throttled   (throttled[c]),
            .busy        (busy[c])
        );
    end

    assign almostFull = {N_CHANNELS{fifo_af}} | throttled;

    a_enq_full:  assert property (@(posedge clk) disable iff (reset) !(enq_any && full));
    a_deq_empty: assert property (@(posedge clk) disable iff (reset) !(deq_en && !head_present));
    a_beats_rng: assert property (@(posedge clk) disable iff (reset) (&beats_ok));

endmodule

// File: tb/tb_cci_mpf_prim_lockstep_qos_fifo.sv
// Randomized scoreboard bench for the lockstep QoS FIFO with a queue/timeline reference model.
module tb_cci_mpf_prim_lockstep_qos_fifo;

    localparam int NC = 2;
    localparam int DW = 16;
    localparam int NE = 16;
    localparam int TH = 8;

    logic            clk;
    logic            reset;
    logic [NC*DW-1:0] enq_data;
    logic [NC-1:0]   enq_valid;
    logic [NC*2-1:0] enq_beats_m1;
    logic [NC-1:0]   enq_counted;
    logic [NC-1:0]   almostFull;
    logic [NC*DW-1:0] first;
    logic [NC-1:0]   first_valid;
    logic            notEmpty;
    logic            deq_en;
    logic            setqos;
    logic            setqos_enable;
    logic [7:0]      setqos_beat_delta;
    logic [7:0]      setqos_min_beats;
    logic [5:0]      setqos_throttle_cyc;
    logic [NC-1:0]   throttled;

    cci_mpf_prim_lockstep_qos_fifo #(
        .N_CHANNELS(NC), .N_DATA_BITS(DW), .THRESHOLD(TH), .N_ENTRIES(NE),
        .MAX_BEATS(4), .REGISTER_OUTPUT(0)
    ) dut (
        .clk(clk), .reset(reset), .enq_data(enq_data), .enq_valid(enq_valid),
        .enq_beats_m1(enq_beats_m1), .enq_counted(enq_counted), .almostFull(almostFull),
        .first(first), .first_valid(first_valid), .notEmpty(notEmpty), .deq_en(deq_en),
        .setqos(setqos), .setqos_enable(setqos_enable), .setqos_beat_delta(setqos_beat_delta),
        .setqos_min_beats(setqos_min_beats), .setqos_throttle_cyc(setqos_throttle_cyc),
        .throttled(throttled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NC*DW-1:0] data;
        logic [NC-1:0]    vld;
        logic [NC*2-1:0]  bm1;
        logic [NC-1:0]    cnt;
    } bundle_t;

    bundle_t mq[$];     // reference FIFO contents
    bundle_t exp_q[$];  // scoreboard of bundles expected at the head on each dequeue

    int vectors = 0;
    int errors  = 0;

    // Reference model state
    int mb[NC];
    int dprev[NC];
    int cfg_en, cfg_delta, cfg_min, cfg_q;
    int act, st, aq;
    int ncyc = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", nm, ncyc, got, exp);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        exp_q.delete();
        for (int c = 0; c < NC; c++) begin mb[c] = 0; dprev[c] = 0; end
        cfg_en = 1; cfg_delta = 6; cfg_min = 0; cfg_q = 8;
        act = -1; st = 0; aq = 0;
    endfunction

    function automatic bit model_trigger(input int c);
        int mo;
        mo = 1 << 30;
        for (int j = 0; j < NC; j++) if (j != c && mb[j] < mo) mo = mb[j];
        return (cfg_en != 0) && (cfg_q != 0) && (mb[c] > mo + cfg_delta) && (mo > cfg_min);
    endfunction

    function automatic bit model_thr(input int c);
        return (act == c) && (ncyc - st < aq);
    endfunction

    function automatic bit model_af(input int c);
        return ((NE - mq.size()) <= TH) || model_thr(c);
    endfunction

    // One clock: predict the edge from the model, advance, then check status outputs
    task automatic step();
        int trig_c;
        int nd[NC];
        bundle_t b;
        bit do_deq;
        trig_c = -1;
        if (act < 0 || (ncyc + 1 - st) > 2 * aq) begin
            for (int c = 0; c < NC; c++) if (trig_c < 0 && model_trigger(c)) trig_c = c;
        end
        do_deq = deq_en && (mq.size() > 0);
        for (int c = 0; c < NC; c++) begin
            nd[c] = 0;
            if (enq_valid[c] && enq_counted[c]) nd[c] += int'(enq_beats_m1[c*2 +: 2]) + 1;
            if (do_deq && mq[0].vld[c] && mq[0].cnt[c]) nd[c] -= int'(mq[0].bm1[c*2 +: 2]) + 1;
        end
        b.data = enq_data; b.vld = enq_valid; b.bm1 = enq_beats_m1; b.cnt = enq_counted;
        @(posedge clk);
        ncyc++;
        if (reset) begin
            model_reset();
        end else begin
            if (trig_c >= 0) begin act = trig_c; st = ncyc; aq = cfg_q; end
            for (int c = 0; c < NC; c++) begin mb[c] += dprev[c]; dprev[c] = nd[c]; end
            if (do_deq) void'(mq.pop_front());
            if (|b.vld) begin mq.push_back(b); exp_q.push_back(b); end
            if (setqos) begin
                cfg_en = int'(setqos_enable); cfg_delta = int'(setqos_beat_delta);
                cfg_min = int'(setqos_min_beats); cfg_q = int'(setqos_throttle_cyc);
            end
        end
        #1;
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("throttled[%0d]", c), 64'(throttled[c]), 64'(model_thr(c)));
            chk($sformatf("almostFull[%0d]", c), 64'(almostFull[c]), 64'(model_af(c)));
        end
        chk("notEmpty", 64'(notEmpty), 64'(mq.size() != 0));
        chk("first_valid", 64'(first_valid), (mq.size() != 0) ? 64'(mq[0].vld) : 64'd0);
    endtask

    // Scoreboard monitor: every accepted dequeue must present the oldest expected bundle
    always @(negedge clk) begin
        if (!reset && deq_en && notEmpty) begin
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL sb_head @cycle %0d: got a head bundle, expected none", ncyc);
            end else begin
                bundle_t e;
                e = exp_q.pop_front();
                chk("first", 64'(first), 64'(e.data));
                chk("deq_first_valid", 64'(first_valid), 64'(e.vld));
            end
        end
    end

    task automatic idle_inputs();
        enq_valid = '0; enq_counted = '0; enq_beats_m1 = '0; deq_en = 1'b0; setqos = 1'b0;
    endtask

    task automatic do_setqos(input bit en, input int d, input int mn, input int q);
        idle_inputs();
        setqos = 1'b1; setqos_enable = en;
        setqos_beat_delta = 8'(d); setqos_min_beats = 8'(mn); setqos_throttle_cyc = 6'(q);
        step();
        setqos = 1'b0;
    endtask

    // Imbalanced traffic: ch0 sends (b0+1)-beat requests, ch1 one-beat requests, both counted
    task automatic imbalance(input int b0, input int deq_level);
        enq_valid = '0; enq_counted = 2'b11;
        enq_beats_m1 = {2'd0, 2'(b0)};
        enq_data = $urandom;
        if (!model_af(0)) enq_valid[0] = 1'b1;
        if (!model_af(1)) enq_valid[1] = 1'b1;
        if (mq.size() >= NE) enq_valid = '0;
        deq_en = (mq.size() >= deq_level);
    endtask

    task automatic drain();
        idle_inputs();
        for (int i = 0; i < 40 && mq.size() > 0; i++) begin
            deq_en = 1'b1;
            step();
        end
        idle_inputs();
        step();
    endtask

    initial begin
        bit hit;
        reset = 1'b1;
        enq_data = '0;
        setqos_enable = 1'b0; setqos_beat_delta = '0; setqos_min_beats = '0; setqos_throttle_cyc = '0;
        idle_inputs();
        model_reset();
        step(); step();
        reset = 1'b0;
        step();

        // Single bundle on ch0, dequeued the following cycle
        enq_valid = 2'b01; enq_data = {16'h0000, 16'h00A5};
        step();
        idle_inputs(); deq_en = 1'b1;
        step();
        idle_inputs();
        step();

        // Fill to full without dequeuing, then drain
        for (int i = 0; i < NE; i++) begin
            enq_data = $urandom; enq_valid = 2'($urandom_range(1, 3));
            enq_beats_m1 = 4'($urandom); enq_counted = '0;
            step();
        end
        idle_inputs();
        chk("full_occupancy", 64'(almostFull), 64'(2'b11));
        drain();

        // Default QoS under beat imbalance
        for (int i = 0; i < 120; i++) begin imbalance(3, 4); step(); end
        drain();

        // QoS disabled, then Q=0, both under imbalance
        do_setqos(1'b0, 6, 0, 8);
        for (int i = 0; i < 60; i++) begin imbalance(3, 4); step(); end
        do_setqos(1'b1, 6, 0, 0);
        for (int i = 0; i < 60; i++) begin imbalance(3, 4); step(); end
        drain();

        // Random traffic with occasional reconfiguration
        for (int i = 0; i < 500; i++) begin
            if (($urandom % 40) == 0) begin
                do_setqos(1'($urandom_range(0, 7) != 0), $urandom_range(0, 8),
                          $urandom_range(0, 3), $urandom_range(0, 5));
            end
            enq_data = $urandom;
            enq_valid = 2'($urandom);
            enq_beats_m1 = 4'($urandom);
            enq_counted = 2'($urandom);
            if (mq.size() >= NE) enq_valid = '0;
            deq_en = (mq.size() > 0) && ($urandom_range(0, 2) != 0);
            step();
        end
        drain();

        // Non-default config, run into a throttle, then reset mid-quantum (with a competing setqos)
        do_setqos(1'b1, 3, 0, 5);
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            imbalance(3, 8);
            step();
            hit = model_thr(0) && (mq.size() >= 4);
        end
        chk("reached_throttle", 64'(hit), 64'd1);
        idle_inputs();
        reset = 1'b1;
        setqos = 1'b1; setqos_enable = 1'b0; setqos_throttle_cyc = 6'd2;
        step();
        reset = 1'b0;
        idle_inputs();
        step();
        chk("post_reset_notEmpty", 64'(notEmpty), 64'd0);
        chk("post_reset_throttled", 64'(throttled), 64'd0);

        // Defaults must be back in force
        for (int i = 0; i < 100; i++) begin imbalance(3, 4); step(); end
        drain();
        chk("sb_leftover", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
